// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC + synchronous imem interface + 2-entry decode buffer.
// Optional macro FETCH_STATS_EN adds stat_delivered/stat_flushed.  Rev 1.0
// ============================================================================
module fetch_unit #(
   parameter int                ADDR_W   = 5,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0]       stat_delivered,
   output logic [15:0]       stat_flushed
`endif
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [1:0]        count;
   logic [31:0]       instr0, instr1;
   logic [ADDR_W-1:0] pc0, pc1;

   logic              pop;
   logic              issue;
   logic [1:0]        remain;
   logic [1:0]        occupancy;

   assign pop       = out_valid & out_ready;
   assign remain    = count - {1'b0, pop};
   // Entries that will be held or owed after this edge; bounds issue so the
   // buffer can always take the memory response.
   assign occupancy = remain + {1'b0, inflight};
   assign issue     = !redirect_valid && (occupancy < 2'd2);

   assign imem_addr = pc_q;
   assign out_valid = (count != 2'd0);
   assign out_instr = out_valid ? instr0 : '0;
   assign out_pc    = out_valid ? pc0    : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q        <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         count       <= 2'd0;
         instr0      <= '0;
         instr1      <= '0;
         pc0         <= '0;
         pc1         <= '0;
      end else if (redirect_valid) begin
         count    <= 2'd0;
         inflight <= 1'b0;
         pc_q     <= redirect_pc;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc_q;
            pc_q        <= pc_q + ADDR_W'(1);
         end
         if (pop) begin
            instr0 <= instr1;
            pc0    <= pc1;
         end
         // A push into an emptied head overrides the shift above.
         if (inflight) begin
            if (remain == 2'd0) begin
               instr0 <= imem_data;
               pc0    <= inflight_pc;
            end else begin
               instr1 <= imem_data;
               pc1    <= inflight_pc;
            end
         end
         count <= occupancy;
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_delivered <= 16'd0;
         stat_flushed   <= 16'd0;
      end else begin
         if (pop)
            stat_delivered <= stat_delivered + 16'd1;
         if (redirect_valid)
            stat_flushed <= stat_flushed + {14'd0, occupancy};
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : table vectors, directed corner sequences and random stimulus
// against a queue-based reference model.  Rev 1.0
// ============================================================================
module tb_fetch_unit;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data = '0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_pc;
`ifdef FETCH_STATS_EN
   logic [15:0]   stat_delivered;
   logic [15:0]   stat_flushed;
`endif

   fetch_unit #(.ADDR_W(AW), .RESET_PC(5'd0)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
`ifdef FETCH_STATS_EN
      ,
      .stat_delivered (stat_delivered),
      .stat_flushed   (stat_flushed)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return 32'h1000_0000 + {27'd0, a};
   endfunction

   // Synchronous instruction memory
   always @(posedge clock) imem_data <= mem_word(imem_addr);

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: PC, one pending memory request, and a queue of
   // fetched-but-undelivered instructions.
   typedef struct {
      logic [31:0]   instr;
      logic [AW-1:0] pc;
   } ent_t;

   ent_t        fifo_q[$];
   int          m_pc;
   bit          m_pend;
   int          m_pend_pc;
   int unsigned m_deliv;
   int unsigned m_flush;

   task automatic model_reset();
      fifo_q.delete();
      m_pc    = 0;
      m_pend  = 1'b0;
      m_pend_pc = 0;
      m_deliv = 0;
      m_flush = 0;
   endtask

   // Drive one cycle of inputs, advance the model across the edge, land on
   // the next falling edge.
   task automatic tick(input bit rv, input int rpc, input bit rdy);
      int occ;
      bit p;
      redirect_valid = rv;
      redirect_pc    = rpc[AW-1:0];
      out_ready      = rdy;
      p   = (fifo_q.size() > 0) && rdy;
      occ = fifo_q.size() - int'(p) + int'(m_pend);
      if (p) m_deliv++;
      if (rv) begin
         m_flush += occ;
         fifo_q.delete();
         m_pend = 1'b0;
         m_pc   = rpc % (1 << AW);
      end else begin
         if (p) void'(fifo_q.pop_front());
         if (m_pend) fifo_q.push_back('{mem_word(m_pend_pc[AW-1:0]), m_pend_pc[AW-1:0]});
         if (occ < 2) begin
            m_pend_pc = m_pc;
            m_pend    = 1'b1;
            m_pc      = (m_pc + 1) % (1 << AW);
         end else begin
            m_pend = 1'b0;
         end
      end
      @(negedge clock);
   endtask

   task automatic check_model(input string tag);
      logic [31:0]   e_instr;
      logic [AW-1:0] e_pc;
      logic [AW-1:0] e_addr;
      bit            ev;
      ev      = (fifo_q.size() > 0);
      e_instr = '0;
      e_pc    = '0;
      if (ev) begin
         e_instr = fifo_q[0].instr;
         e_pc    = fifo_q[0].pc;
      end
      e_addr = m_pc[AW-1:0];
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
      chk({tag, ".pc"},    {27'd0, out_pc},    {27'd0, e_pc});
      chk({tag, ".instr"}, out_instr,          e_instr);
      chk({tag, ".addr"},  {27'd0, imem_addr}, {27'd0, e_addr});
`ifdef FETCH_STATS_EN
      chk({tag, ".deliv"}, {16'd0, stat_delivered}, {16'd0, m_deliv[15:0]});
      chk({tag, ".flush"}, {16'd0, stat_flushed},   {16'd0, m_flush[15:0]});
`endif
   endtask

   typedef struct {
      bit ready;
      bit exp_valid;
      int exp_pc;
      int exp_addr;
   } vec_t;

   vec_t vecs[15];

   task automatic run_table(input string tag);
      for (int i = 0; i < 15; i++) begin
         logic [31:0] ei;
         logic [AW-1:0] epc;
         logic [AW-1:0] ea;
         epc = vecs[i].exp_pc[AW-1:0];
         ea  = vecs[i].exp_addr[AW-1:0];
         ei  = vecs[i].exp_valid ? mem_word(epc) : 32'd0;
         chk($sformatf("%s[%0d].valid", tag, i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
         chk($sformatf("%s[%0d].pc", tag, i),    {27'd0, out_pc},    vecs[i].exp_valid ? {27'd0, epc} : 32'd0);
         chk($sformatf("%s[%0d].instr", tag, i), out_instr,          ei);
         chk($sformatf("%s[%0d].addr", tag, i),  {27'd0, imem_addr}, {27'd0, ea});
         tick(1'b0, 0, vecs[i].ready);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fl_before;
      int dl_before;
      // cycle: ready, valid, pc, addr  (cycle 0 = first cycle after release)
      vecs[0]  = '{1, 0, 0, 0};
      vecs[1]  = '{1, 0, 0, 1};
      vecs[2]  = '{1, 1, 0, 2};
      vecs[3]  = '{1, 1, 1, 3};
      vecs[4]  = '{1, 1, 2, 4};
      vecs[5]  = '{0, 1, 3, 5};
      vecs[6]  = '{0, 1, 3, 5};
      vecs[7]  = '{0, 1, 3, 5};
      vecs[8]  = '{0, 1, 3, 5};
      vecs[9]  = '{0, 1, 3, 5};
      vecs[10] = '{1, 1, 3, 5};
      vecs[11] = '{1, 1, 4, 6};
      vecs[12] = '{1, 1, 5, 7};
      vecs[13] = '{1, 1, 6, 8};
      vecs[14] = '{1, 1, 7, 9};

      model_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst.valid", {31'd0, out_valid}, 32'd0);
      chk("rst.instr", out_instr, 32'd0);
      chk("rst.pc",    {27'd0, out_pc}, 32'd0);
      chk("rst.addr",  {27'd0, imem_addr}, 32'd0);
`ifdef FETCH_STATS_EN
      chk("rst.deliv", {16'd0, stat_delivered}, 32'd0);
      chk("rst.flush", {16'd0, stat_flushed}, 32'd0);
`endif
      reset_n = 1'b1;
      run_table("tab");

      // Fill both buffer entries, then redirect while stalled
      tick(1'b0, 0, 1'b0);
      tick(1'b0, 0, 1'b0);
      check_model("prered");
      fl_before = int'(m_flush);
      tick(1'b1, 16, 1'b0);
      chk("red.t1.valid", {31'd0, out_valid}, 32'd0);
      chk("red.t1.addr",  {27'd0, imem_addr}, 32'h10);
      check_model("red.t1");
      tick(1'b0, 0, 1'b1);
      chk("red.t2.valid", {31'd0, out_valid}, 32'd0);
      tick(1'b0, 0, 1'b1);
      chk("red.t3.valid", {31'd0, out_valid}, 32'd1);
      chk("red.t3.pc",    {27'd0, out_pc}, 32'h10);
      chk("red.t3.instr", out_instr, 32'h1000_0010);
`ifdef FETCH_STATS_EN
      chk("red.flushed", {16'd0, stat_flushed}, 32'((fl_before + 2) & 16'hFFFF));
`endif
      check_model("red.t3");

      // Address wrap
      tick(1'b1, 31, 1'b1);
      tick(1'b0, 0, 1'b1);
      tick(1'b0, 0, 1'b1);
      chk("wrap.pc0", {27'd0, out_pc}, 32'h1F);
      check_model("wrap0");
      tick(1'b0, 0, 1'b1);
      chk("wrap.pc1", {27'd0, out_pc}, 32'h00);
      tick(1'b0, 0, 1'b1);
      chk("wrap.pc2", {27'd0, out_pc}, 32'h01);
      check_model("wrap2");

      // Redirect coincident with a pop, followed by a second redirect
      chk("pop.pre.valid", {31'd0, out_valid}, 32'd1);
      dl_before = int'(m_deliv);
      tick(1'b1, 8, 1'b1);
      tick(1'b1, 12, 1'b1);
      chk("dbl.t1.valid", {31'd0, out_valid}, 32'd0);
      chk("dbl.t1.addr",  {27'd0, imem_addr}, 32'h0C);
`ifdef FETCH_STATS_EN
      chk("dbl.deliv", {16'd0, stat_delivered}, 32'((dl_before + 1) & 16'hFFFF));
`endif
      tick(1'b0, 0, 1'b1);
      chk("dbl.t2.valid", {31'd0, out_valid}, 32'd0);
      tick(1'b0, 0, 1'b1);
      chk("dbl.t3.pc", {27'd0, out_pc}, 32'h0C);
      check_model("dbl.t3");
      tick(1'b0, 0, 1'b1);
      chk("dbl.t4.pc", {27'd0, out_pc}, 32'h0D);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         bit rv;
         bit rdy;
         int rpc;
         rv  = ($urandom_range(0, 7) == 0);
         rpc = int'($urandom_range(0, 31));
         rdy = ($urandom_range(0, 9) < 7);
         check_model("rnd");
         tick(rv, rpc, rdy);
      end

      // Asynchronous reset with two entries buffered
      repeat (3) tick(1'b0, 0, 1'b1);
      tick(1'b0, 0, 1'b0);
      tick(1'b0, 0, 1'b0);
      check_model("prerst");
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst.valid", {31'd0, out_valid}, 32'd0);
      chk("arst.addr",  {27'd0, imem_addr}, 32'd0);
      chk("arst.pc",    {27'd0, out_pc}, 32'd0);
      chk("arst.instr", out_instr, 32'd0);
      model_reset();
      out_ready = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      run_table("tab2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
